// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - scan sequencer driving a 3-to-8 decoder select/enable
module decoder_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  localparam int DW_W = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam int BL_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
  localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);
  localparam logic [BL_W-1:0] BLANK_LOAD = BL_W'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t          state, state_d;
  logic [7:0]      mask_q, mask_q_d;
  logic            stop_pend, stop_pend_d;
  logic [DW_W-1:0] dwell_cnt, dwell_cnt_d;
  logic [BL_W-1:0] blank_cnt, blank_cnt_d;
  logic [2:0]      sel_d;
  logic            en_d, busy_d, frame_done_d;
  logic            enter_sel, go_idle, stop_now;
  logic [3:0]      nxt_above, first_new;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign nxt_above = find_from(mask_q, {1'b0, sel} + 4'd1);
  assign first_new = find_from(mask, 4'd0);
  assign stop_now  = stop_pend | stop;

  always_comb begin
    state_d      = state;
    sel_d        = sel;
    en_d         = en;
    busy_d       = busy;
    frame_done_d = 1'b0;
    mask_q_d     = mask_q;
    stop_pend_d  = stop_pend;
    dwell_cnt_d  = dwell_cnt;
    blank_cnt_d  = blank_cnt;
    enter_sel    = 1'b0;
    go_idle      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && (mask != 8'd0)) begin
          mask_q_d  = mask;
          sel_d     = first_new[2:0];
          enter_sel = 1'b1;
        end
      end
      S_BLANK: begin
        if (stop) stop_pend_d = 1'b1;
        if (blank_cnt == '0) begin
          state_d     = S_DRIVE;
          en_d        = 1'b1;
          dwell_cnt_d = DWELL_LOAD;
        end else begin
          blank_cnt_d = blank_cnt - 1'b1;
        end
      end
      S_DRIVE: begin
        if (stop) stop_pend_d = 1'b1;
        if (dwell_cnt != '0) begin
          dwell_cnt_d = dwell_cnt - 1'b1;
        end else if (nxt_above[3]) begin
          if (stop_now) begin
            go_idle = 1'b1;
          end else begin
            sel_d     = nxt_above[2:0];
            enter_sel = 1'b1;
          end
        end else begin
          // Frame end: continuous mode re-latches the live mask for the next frame.
          frame_done_d = 1'b1;
          if (cont && !stop_now) begin
            mask_q_d = mask;
            if (first_new[3]) begin
              sel_d     = first_new[2:0];
              enter_sel = 1'b1;
            end else begin
              go_idle = 1'b1;
            end
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (enter_sel) begin
      busy_d = 1'b1;
      if (BLANK > 0) begin
        state_d     = S_BLANK;
        en_d        = 1'b0;
        blank_cnt_d = BLANK_LOAD;
      end else begin
        state_d     = S_DRIVE;
        en_d        = 1'b1;
        dwell_cnt_d = DWELL_LOAD;
      end
    end

    if (go_idle) begin
      state_d     = S_IDLE;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel        <= 3'd0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mask_q     <= 8'd0;
      stop_pend  <= 1'b0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      en         <= en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      mask_q     <= mask_q_d;
      stop_pend  <= stop_pend_d;
      dwell_cnt  <= dwell_cnt_d;
      blank_cnt  <= blank_cnt_d;
    end
  end

endmodule
